// File: rtl/k6502_int_seq_pkg.sv
// Shared types and constants for the 6502 instruction cycle / interrupt sequencer.
// Interrupt kinds, vector addresses and the irq_src width helper live here.
package k6502_int_seq_pkg;

   typedef enum logic [1:0] {
      INT_NONE = 2'd0,
      INT_RST  = 2'd1,
      INT_NMI  = 2'd2,
      INT_IRQ  = 2'd3
   } int_kind_e;

   localparam logic [15:0] VEC_RST = 16'hFFFC;
   localparam logic [15:0] VEC_NMI = 16'hFFFA;
   localparam logic [15:0] VEC_IRQ = 16'hFFFE;

   // A single IRQ channel still needs a 1-bit index.
   function automatic int src_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/k6502_int_seq_if.sv
// Bundle between mcode/interrupt sources (master) and the sequencer (slave).
// The master drives the sequencing inputs; the slave returns cycle/sync/vector state.
interface k6502_int_seq_if
   import k6502_int_seq_pkg::*;
#(
   parameter int CYCLE_BITS = 6,
   parameter int NUM_IRQ    = 4
);
   localparam int SRC_W = src_w(NUM_IRQ);

   logic                  next_sync;
   logic                  rdy;
   logic                  nmi_n;
   logic [NUM_IRQ-1:0]    irq_n;
   logic [NUM_IRQ-1:0]    irq_mask;
   logic                  i_flag;

   logic [CYCLE_BITS-1:0] cycle;
   logic                  sync;
   logic                  int_active;
   int_kind_e             int_kind;
   logic [15:0]           vec_addr;
   logic [SRC_W-1:0]      irq_src;
   logic                  int_ack;
   logic                  overrun;

   modport master (
      output next_sync, rdy, nmi_n, irq_n, irq_mask, i_flag,
      input  cycle, sync, int_active, int_kind, vec_addr, irq_src, int_ack, overrun
   );

   modport slave (
      input  next_sync, rdy, nmi_n, irq_n, irq_mask, i_flag,
      output cycle, sync, int_active, int_kind, vec_addr, irq_src, int_ack, overrun
   );

endinterface

// File: rtl/k6502_int_seq_irq_prio.sv
// Lowest-index-wins priority encoder over the eligible IRQ channels.
module k6502_int_seq_irq_prio #(
   parameter int NUM_IRQ = 4,
   parameter int SRC_W   = 2
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               any,
   output logic [SRC_W-1:0]   idx
);

   // Scan from the top down so the lowest requesting index is written last.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            any = 1'b1;
            idx = SRC_W'(i);
         end
      end
   end

endmodule

// File: rtl/k6502_int_seq.sv
// Instruction cycle sequencer: cycle counter, sync pulse, RDY stall, and
// RST/NMI/IRQ arbitration at instruction boundaries with vector selection.
module k6502_int_seq
   import k6502_int_seq_pkg::*;
#(
   parameter int CYCLE_BITS = 6,
   parameter int MAX_CYCLE  = 7,
   parameter int NUM_IRQ    = 4
) (
   input logic            clk,
   input logic            rst_n,
   k6502_int_seq_if.slave bus
);

   localparam int SRC_W = src_w(NUM_IRQ);
   localparam logic [CYCLE_BITS-1:0] CYC_MAX = CYCLE_BITS'(MAX_CYCLE);

   logic [CYCLE_BITS-1:0] cycle_q, cycle_d;
   logic                  sync_q, sync_d;
   logic                  active_q, active_d;
   int_kind_e             kind_q, kind_d;
   logic [15:0]           vec_q, vec_d;
   logic [SRC_W-1:0]      src_q, src_d;
   logic                  ack_q, ack_d;
   logic                  ovr_q, ovr_d;
   logic                  nmi_latch_q, nmi_latch_d;
   logic                  nmi_hist_q;

   logic [NUM_IRQ-1:0]    irq_elig;
   logic                  irq_any;
   logic [SRC_W-1:0]      irq_idx;
   logic                  boundary;

   assign irq_elig = ~bus.irq_n & bus.irq_mask & {NUM_IRQ{~bus.i_flag}};
   assign boundary = bus.rdy & bus.next_sync;

   k6502_int_seq_irq_prio #(
      .NUM_IRQ (NUM_IRQ),
      .SRC_W   (SRC_W)
   ) u_irq_prio (
      .req (irq_elig),
      .any (irq_any),
      .idx (irq_idx)
   );

   always_comb begin
      cycle_d     = cycle_q;
      sync_d      = sync_q;
      active_d    = active_q;
      kind_d      = kind_q;
      vec_d       = vec_q;
      src_d       = src_q;
      ack_d       = 1'b0;
      ovr_d       = ovr_q;
      nmi_latch_d = nmi_latch_q;

      if (boundary) begin
         cycle_d = '0;
         sync_d  = 1'b1;
         ack_d   = active_q;
         if (nmi_latch_q) begin
            active_d    = 1'b1;
            kind_d      = INT_NMI;
            vec_d       = VEC_NMI;
            nmi_latch_d = 1'b0;
         end else if (irq_any) begin
            active_d = 1'b1;
            kind_d   = INT_IRQ;
            vec_d    = VEC_IRQ;
            src_d    = irq_idx;
         end else begin
            active_d = 1'b0;
            kind_d   = INT_NONE;
            vec_d    = VEC_IRQ;
         end
      end else if (bus.rdy) begin
         sync_d = 1'b0;
         if (cycle_q == CYC_MAX) ovr_d = 1'b1;
         else                    cycle_d = cycle_q + CYCLE_BITS'(1);
      end

      // A fresh NMI edge on the taking edge must survive to the next boundary.
      if (nmi_hist_q & ~bus.nmi_n) nmi_latch_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q     <= '0;
         sync_q      <= 1'b0;
         active_q    <= 1'b1;
         kind_q      <= INT_RST;
         vec_q       <= VEC_RST;
         src_q       <= '0;
         ack_q       <= 1'b0;
         ovr_q       <= 1'b0;
         nmi_latch_q <= 1'b0;
         nmi_hist_q  <= 1'b1;
      end else begin
         cycle_q     <= cycle_d;
         sync_q      <= sync_d;
         active_q    <= active_d;
         kind_q      <= kind_d;
         vec_q       <= vec_d;
         src_q       <= src_d;
         ack_q       <= ack_d;
         ovr_q       <= ovr_d;
         nmi_latch_q <= nmi_latch_d;
         nmi_hist_q  <= bus.nmi_n;
      end
   end

   assign bus.cycle      = cycle_q;
   assign bus.sync       = sync_q;
   assign bus.int_active = active_q;
   assign bus.int_kind   = kind_q;
   assign bus.vec_addr   = vec_q;
   assign bus.irq_src    = src_q;
   assign bus.int_ack    = ack_q;
   assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_k6502_int_seq.sv
// Scoreboarded bench for k6502_int_seq: directed scenarios then random traffic,
// checked against an instruction-level reference model.
module tb_k6502_int_seq;

   localparam int NIRQ   = 4;
   localparam int MAXC   = 7;
   localparam int K_NONE = 0, K_RST = 1, K_NMI = 2, K_IRQ = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   k6502_int_seq_if #(.CYCLE_BITS(6), .NUM_IRQ(NIRQ)) bus ();

   k6502_int_seq #(.CYCLE_BITS(6), .MAX_CYCLE(MAXC), .NUM_IRQ(NIRQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int          tgt;
      logic [5:0]  cyc;
      logic        sync;
      logic        act;
      logic [1:0]  kind;
      logic [15:0] vec;
      logic [1:0]  src;
      logic        ack;
      logic        ovr;
   } exp_t;

   exp_t sbq[$];
   int   edge_cnt = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // stimulus knobs
   bit         rst_v = 1'b0, ns = 1'b0, rdy = 1'b1, nmi = 1'b1, ifl = 1'b0;
   logic [3:0] irqn = 4'hF, msk = 4'h0;

   // reference model: instruction-level view of the sequencer
   int m_cyc, m_kind, m_src;
   bit m_sync, m_ack, m_ovr, m_npend, m_nprev;

   function automatic void m_reset();
      m_cyc = 0; m_sync = 0; m_kind = K_RST; m_src = 0;
      m_ack = 0; m_ovr = 0; m_npend = 0; m_nprev = 1;
   endfunction

   function automatic void m_edge();
      bit         fell;
      logic [3:0] el;
      int         j;
      fell    = m_nprev && !nmi;
      m_nprev = nmi;
      m_ack   = 0;
      if (rdy && ns) begin
         m_ack  = (m_kind != K_NONE);
         m_sync = 1;
         m_cyc  = 0;
         el     = ifl ? 4'h0 : (~irqn & msk);
         if (m_npend) begin
            m_kind  = K_NMI;
            m_npend = 0;
         end else if (el != 0) begin
            m_kind = K_IRQ;
            j = 0;
            while (!el[j]) j++;
            m_src = j;
         end else begin
            m_kind = K_NONE;
         end
      end else if (rdy) begin
         m_sync = 0;
         if (m_cyc == MAXC) m_ovr = 1;
         m_cyc = (m_cyc + 1 > MAXC) ? MAXC : m_cyc + 1;
      end
      if (fell) m_npend = 1;
   endfunction

   function automatic void push(input int t);
      exp_t e;
      e.tgt  = t;
      e.cyc  = 6'(m_cyc);
      e.sync = m_sync;
      e.act  = (m_kind != K_NONE);
      e.kind = 2'(m_kind);
      e.vec  = (m_kind == K_RST) ? 16'hFFFC : (m_kind == K_NMI) ? 16'hFFFA : 16'hFFFE;
      e.src  = 2'(m_src);
      e.ack  = m_ack;
      e.ovr  = m_ovr;
      sbq.push_back(e);
   endfunction

   // Called at posedge+2: apply inputs, predict the state after the next edge.
   task automatic step();
      bus.next_sync = ns;
      bus.rdy       = rdy;
      bus.nmi_n     = nmi;
      bus.irq_n     = irqn;
      bus.irq_mask  = msk;
      bus.i_flag    = ifl;
      if (!rst_v) begin
         rst_n = 1'b0;
         m_reset();
         sbq.delete();
         push(edge_cnt);
         push(edge_cnt + 1);
      end else begin
         rst_n = 1'b1;
         m_edge();
         push(edge_cnt + 1);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // monitor: outputs are presented every cycle, sampled on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].tgt <= edge_cnt) begin
            e = sbq.pop_front();
            n_vec++;
            if (e.tgt != edge_cnt || bus.cycle !== e.cyc || bus.sync !== e.sync ||
                bus.int_active !== e.act || 2'(bus.int_kind) !== e.kind ||
                bus.vec_addr !== e.vec || bus.irq_src !== e.src ||
                bus.int_ack !== e.ack || bus.overrun !== e.ovr) begin
               n_err++;
               $display("FAIL outputs edge %0d (tgt %0d): got cyc=%0d sync=%b act=%b kind=%0d vec=%h src=%0d ack=%b ovr=%b, expected cyc=%0d sync=%b act=%b kind=%0d vec=%h src=%0d ack=%b ovr=%b",
                        edge_cnt, e.tgt, bus.cycle, bus.sync, bus.int_active, bus.int_kind,
                        bus.vec_addr, bus.irq_src, bus.int_ack, bus.overrun,
                        e.cyc, e.sync, e.act, e.kind, e.vec, e.src, e.ack, e.ovr);
            end
         end
      end
   end

   initial begin
      bus.next_sync = 1'b0; bus.rdy = 1'b1; bus.nmi_n = 1'b1;
      bus.irq_n = 4'hF; bus.irq_mask = 4'h0; bus.i_flag = 1'b0;
      @(posedge clk);
      #2;

      // reset, RST instruction of 4 cycles, then a plain instruction
      rst_v = 0; run(2);
      rst_v = 1; rdy = 1; ns = 0; run(3);
      ns = 1; run(1);
      ns = 0; run(2);
      ns = 1; run(1);

      // NMI edge during a stall, then a second edge on the taking edge
      ns = 0; rdy = 0; nmi = 0; run(5);
      rdy = 1; nmi = 1; run(1);
      ns = 1; nmi = 0; run(1);
      ns = 0; nmi = 1; run(2);
      ns = 1; run(1);

      // IRQ: channels 1,2 low, 2,3 enabled -> channel 2; then blocked by I
      ns = 0; run(1);
      irqn = 4'b1001; msk = 4'b1100; ifl = 0; ns = 1; run(1);
      ns = 0; run(1);
      ifl = 1; ns = 1; run(2);

      // NMI and IRQ pending together: NMI first, IRQ next
      ifl = 0; ns = 0; nmi = 0; run(1);
      nmi = 1; run(1);
      ns = 1; run(1);
      ns = 0; run(1);
      ns = 1; run(1);

      // overrun: saturate, stays sticky across boundaries, cleared by reset
      irqn = 4'hF; ns = 0; run(MAXC + 3);
      ns = 1; run(2);
      rst_v = 0; run(1);
      rst_v = 1; ns = 0; run(1);

      // async reset at cycle 4 of an IRQ sequence with an NMI pending
      irqn = 4'b1110; msk = 4'b0001; ns = 1; run(1);
      ns = 0; nmi = 0; run(4);
      rst_v = 0; run(1);
      rst_v = 1; nmi = 1; irqn = 4'hF; ns = 0; run(2);
      ns = 1; run(2);

      // random traffic
      for (int r = 0; r < 2000; r++) begin
         rst_v = ($urandom_range(0, 99) != 0);
         rdy   = ($urandom_range(0, 3) != 0);
         ns    = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) nmi = ~nmi;
         irqn  = 4'($urandom);
         msk   = 4'($urandom);
         ifl   = 1'($urandom);
         step();
      end

      repeat (3) @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/k6502_int_seq.md
Name: k6502_int_seq

Overview:
Parametrised successor to the core's instruction cycle sequencer. It generates the per-instruction cycle count and the sync pulse for the mcode block. It also adds capabilities the current sequencer lacks: RDY stall, and reset/NMI/IRQ arbitration at instruction boundaries with vector selection. It sits between mcode (which supplies next_sync) and the core's addressing/ir path, which consume sync, cycle and vec_addr.

Parameters:
CYCLE_BITS, 6, width of the cycle counter.
MAX_CYCLE, 7, highest legal cycle index; reaching it without next_sync is an overrun.
NUM_IRQ, 4, number of independent level-sensitive IRQ channels.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
next_sync  in  1  from mcode: the current cycle is the last cycle of the instruction.
rdy  in  1  1 = advance; 0 = stall (hold all sequencing state).
nmi_n  in  1  NMI request, active-low, falling-edge sensitive.
irq_n  in  NUM_IRQ  IRQ requests, active-low, level-sensitive.
irq_mask  in  NUM_IRQ  1 = channel enabled.
i_flag  in  1  processor I flag; 1 blocks IRQ.
cycle  out  CYCLE_BITS  cycle index within the current instruction.
sync  out  1  high during cycle 0 (opcode fetch) of each instruction.
int_active  out  1  the current instruction is an interrupt sequence.
int_kind  out  2  INT_NONE, INT_RST, INT_NMI or INT_IRQ, latched for the sequence.
vec_addr  out  16  FFFC (RST), FFFA (NMI), FFFE (IRQ); FFFE when INT_NONE.
irq_src  out  max(1,clog2(NUM_IRQ))  winning IRQ channel, latched with int_kind.
int_ack  out  1  one-cycle pulse at the boundary that ends an interrupt sequence.
overrun  out  1  sticky error flag.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - cycle=0, sync=0.
  - int_active=1, int_kind=INT_RST, vec_addr=FFFC.
  - irq_src=0, int_ack=0, overrun=0.
  - NMI latch cleared; nmi_n history register set to 1.
- The first instruction after reset is always the RST sequence. The first rising edge with rst_n=1 and rdy=1 advances cycle to 1.
- Instruction boundary: rdy=1 and next_sync=1.
  - Next state: cycle<=0, sync<=1.
- Other advancing cycle (rdy=1, next_sync=0):
  - sync<=0.
  - cycle<=cycle+1, saturating at MAX_CYCLE.
  - If cycle==MAX_CYCLE at that edge, overrun<=1. overrun is sticky until reset.
- Stall (rdy=0): cycle, sync, int_* and irq_src hold. int_ack<=0. NMI edge detection continues.
- NMI edge detector:
  - nmi_n is registered every clock.
  - A registered 1 followed by a current 0 sets nmi_latch.
  - If set and clear coincide, set wins.
- Arbitration is evaluated only at the instruction boundary, with priority NMI > IRQ > none. RST occurs only through reset.
  - IRQ is eligible when i_flag=0 and (~irq_n & irq_mask) is non-zero. irq_src is the lowest eligible index.
  - Winner NMI: int_active<=1, int_kind<=INT_NMI, vec_addr<=FFFA, nmi_latch cleared.
  - Winner IRQ: int_active<=1, int_kind<=INT_IRQ, vec_addr<=FFFE, irq_src latched.
  - No winner: int_active<=0, int_kind<=INT_NONE, vec_addr<=FFFE.
- int_ack:
  - Pulses for one cycle on the edge after a boundary taken while int_active=1.
  - Back-to-back interrupts are allowed: ack for the old sequence and latch of the new kind happen on the same edge.
- IRQ is level-sensitive and not latched. A request released before a boundary is lost.
- Masking or setting i_flag mid-instruction has no effect until the next boundary.
- Reset asserted mid-instruction or mid-interrupt aborts immediately to reset values. A pending NMI is discarded.

Decomposition:
- Add to k6502_defs.v:
  - INT_NONE=0, INT_RST=1, INT_NMI=2, INT_IRQ=3.
  - VEC_RST=16'hFFFC, VEC_NMI=16'hFFFA, VEC_IRQ=16'hFFFE.
- One combinational sub-module, irq_prio. It is a parametrised lowest-index priority encoder with inputs req[NUM_IRQ-1:0] and outputs any, idx.
- The top holds the counter, NMI edge detector and boundary latch logic.

Test Plan:
- Reset release, rdy=1, next_sync on cycle 3 → cycle 0,1,2,3,0; sync=1 at cycles 0; int_kind=RST and vec_addr=FFFC for the first instruction; int_ack pulses after it; second instruction has int_kind=NONE.
- nmi_n falling while rdy=0 for 5 cycles, then a boundary → the NMI is still taken: int_kind=NMI, vec_addr=FFFA; nmi_latch cleared; a second NMI edge arriving on the taking cycle is taken at the following boundary.
- irq_n=4'b1001 (channels 1,2 low), irq_mask=4'b1100, i_flag=0 at a boundary → INT_IRQ, irq_src=2, vec_addr=FFFE; repeat with i_flag=1 → INT_NONE.
- NMI and IRQ pending at the same boundary → NMI first; IRQ, still asserted, is taken at the next boundary with int_ack between them.
- next_sync held 0 for MAX_CYCLE+3 cycles → cycle saturates at 7 and overrun=1; overrun stays 1 after later boundaries; rst_n pulse clears it.
- rst_n asserted asynchronously mid-cycle during an IRQ sequence at cycle 4 → outputs go to reset values before the next clock edge; nmi_latch cleared.
